// File: rtl/result_stream_splitter_if.sv
// Signal bundle for result_stream_splitter: run control, 64-bit core input, split 32-bit lanes, status.
// master = splitter side, slave = surrounding system; drop_count exists only when DROP_COUNT_EN is defined.
interface result_stream_splitter_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             reset_op;
    logic [CNT_W-1:0] n_samples;
    logic             in_valid;
    logic [63:0]      in_data;
    logic             in_ready;
    logic             up_valid;
    logic [31:0]      up_data;
    logic             up_ready;
    logic             down_valid;
    logic [31:0]      down_data;
    logic             down_ready;
    logic [CNT_W-1:0] sample_count;
    logic             finalizacion;
    logic             overflow;
`ifdef DROP_COUNT_EN
    logic [15:0]      drop_count;
`endif

    modport master (
        input  enable, reset_op, n_samples, in_valid, in_data, up_ready, down_ready,
        output in_ready, up_valid, up_data, down_valid, down_data,
        output sample_count, finalizacion, overflow
`ifdef DROP_COUNT_EN
        , output drop_count
`endif
    );

    modport slave (
        output enable, reset_op, n_samples, in_valid, in_data, up_ready, down_ready,
        input  in_ready, up_valid, up_data, down_valid, down_data,
        input  sample_count, finalizacion, overflow
`ifdef DROP_COUNT_EN
        , input drop_count
`endif
    );
endinterface

// File: rtl/result_stream_splitter.sv
// Buffers 64-bit core results in a DEPTH-entry FIFO and splits each entry onto two 32-bit valid/ready lanes.
// Latency: a push is visible on both lanes one cycle later; an entry pops once both lanes have taken it.
// Backpressure: in_ready = RUN && !full && target not reached; optional DROP_COUNT_EN adds a saturating drop counter.
module result_stream_splitter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input logic                      clk,
    input logic                      reset,
    result_stream_splitter_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W:0] ACC_ONE = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic             enable_q;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [63:0]      mem_q [DEPTH];
    logic             up_taken_q, up_taken_d, down_taken_q, down_taken_d;
    logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
`ifdef DROP_COUNT_EN
    logic [15:0]      drop_q, drop_d;
`endif

    logic             empty, full, target_hit, last_push;
    logic             push, pop, up_hs, down_hs, up_done, down_done, ovf_event;
    logic [CNT_W:0]   acc_plus1;
    logic [63:0]      head;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Target compare is re-evaluated every cycle so a lowered n_samples stops intake immediately.
    assign target_hit = (bus.n_samples != '0) && (acc_q >= bus.n_samples);
    assign acc_plus1  = {1'b0, acc_q} + ACC_ONE;
    assign last_push  = (bus.n_samples != '0) && (acc_plus1 >= {1'b0, bus.n_samples});

    assign bus.in_ready = (state_q == RUN) && !full && !target_hit;
    assign push         = bus.in_valid && bus.in_ready;
    assign ovf_event    = (state_q == RUN) && bus.in_valid && !bus.in_ready && !target_hit;

    assign head           = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.up_valid   = !empty && !up_taken_q;
    assign bus.down_valid = !empty && !down_taken_q;
    assign bus.up_data    = empty ? 32'd0 : head[63:32];
    assign bus.down_data  = empty ? 32'd0 : head[31:0];

    assign up_hs     = bus.up_valid && bus.up_ready;
    assign down_hs   = bus.down_valid && bus.down_ready;
    assign up_done   = up_taken_q || up_hs;
    assign down_done = down_taken_q || down_hs;
    assign pop       = !empty && up_done && down_done;

    assign bus.sample_count = cnt_q;
    assign bus.finalizacion = (state_q == DONE);
    assign bus.overflow     = overflow_q;
`ifdef DROP_COUNT_EN
    assign bus.drop_count   = drop_q;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d     = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        up_taken_d   = pop ? 1'b0 : up_done;
        down_taken_d = pop ? 1'b0 : down_done;
        acc_d        = push ? acc_plus1[CNT_W-1:0] : acc_q;
        cnt_d        = pop ? (cnt_q + CNT_ONE) : cnt_q;
        overflow_d   = overflow_q || ovf_event;
`ifdef DROP_COUNT_EN
        drop_d       = (ovf_event && (drop_q != 16'hFFFF)) ? (drop_q + 16'd1) : drop_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.enable && !enable_q) begin
                    state_d    = RUN;
                    acc_d      = '0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
`ifdef DROP_COUNT_EN
                    drop_d     = 16'd0;
`endif
                end
            end
            RUN: begin
                if (!bus.enable || target_hit || (push && last_push)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Taken flags are only ever set on a non-empty FIFO, so empty implies no pending lane word.
                if (empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.reset_op) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            up_taken_d   = 1'b0;
            down_taken_d = 1'b0;
            acc_d        = '0;
            cnt_d        = '0;
            overflow_d   = 1'b0;
`ifdef DROP_COUNT_EN
            drop_d       = 16'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            enable_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            up_taken_q   <= 1'b0;
            down_taken_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
`ifdef DROP_COUNT_EN
            drop_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            enable_q     <= bus.enable;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            up_taken_q   <= up_taken_d;
            down_taken_q <= down_taken_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
`ifdef DROP_COUNT_EN
            drop_q       <= drop_d;
`endif
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
        end
    end
endmodule

// File: doc/result_stream_splitter.md
Name: result_stream_splitter

Overview:
- Upstream feeder for the processor's 64-bit stream sinks (fifo*_64_bit_up_in / fifo*_64_bit_down_in).
- Takes 64-bit results from a free-running processing core and buffers them in a DEPTH-entry FIFO.
- Splits each entry into an upper and a lower 32-bit word and drives two independent valid/ready streams.
- Counts samples up to a programmed total, drains the FIFO, then asserts a completion flag for finalizacion_export.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- CNT_W, 32, width of the sample target and the sample counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request (from enable_export)
- reset_op  in  1  synchronous clear (from reset_op_export)
- n_samples  in  CNT_W  samples per run; 0 = unlimited
- in_valid  in  1  core result valid
- in_data  in  64  core result
- in_ready  out  1  FIFO can accept this cycle
- up_valid  out  1  upper-word stream valid
- up_data  out  32  in_data[63:32] of FIFO head
- up_ready  in  1  upper sink ready
- down_valid  out  1  lower-word stream valid
- down_data  out  32  in_data[31:0] of FIFO head
- down_ready  in  1  lower sink ready
- sample_count  out  CNT_W  entries fully delivered on both lanes
- finalizacion  out  1  run complete
- overflow  out  1  sticky: a sample arrived while it could not be accepted

Behaviour:
- Reset (async, and reset_op sync) forces:
  - state=IDLE; FIFO empty; lane-taken flags clear.
  - Accept counter and sample_count = 0.
  - overflow=0, finalizacion=0, in_ready=0, up_valid=0, down_valid=0, data outputs 0.
- State machine:
  - IDLE: in_ready=0. On an enable rising edge (registered previous value is 0, current is 1): clear both counters and overflow, go to RUN.
  - RUN: in_ready = !full. Push when in_valid && in_ready. Go to DRAIN when enable=0, or when n_samples!=0 and the accept counter reaches n_samples on this push.
  - DRAIN: in_ready=0, no pushes. Go to DONE when the FIFO is empty and neither lane has a pending word.
  - DONE: finalizacion=1 (registered, asserted the cycle DONE is entered). Go to IDLE when enable=0; finalizacion clears on that exit.
- Overflow:
  - Set in RUN when in_valid=1 and in_ready=0, but only while the target is not yet reached.
  - In IDLE, DRAIN and DONE, in_valid is ignored and does not set overflow.
- FIFO:
  - Registered pointers of width log2(DEPTH)+1; full/empty come from the pointer MSB compare.
  - No same-cycle bypass: a push into an empty FIFO is visible on up/down one cycle later.
  - in_ready is not combinationally dependent on a pop in the same cycle.
- Lane split:
  - The head entry is presented on both lanes at once.
  - up_valid = !empty && !up_taken; down_valid = !empty && !down_taken.
  - A lane handshake (valid && ready) with the other lane not yet done sets that lane's taken flag.
  - The entry pops when both lanes are done: flag set or handshaking this cycle, including both handshaking in the same cycle.
  - On pop: both flags clear, sample_count increments, the next head appears the following cycle. There is no dead cycle if the next entry is already stored.
  - Data on a lane stays stable while its valid is high and ready is low.
- Counters:
  - The accept counter wraps modulo 2^CNT_W when n_samples=0.
  - sample_count wraps modulo 2^CNT_W.
- Simultaneous events:
  - Push and pop in the same cycle leave occupancy unchanged.
  - reset_op wins over every other event.
  - An enable drop in RUN in the same cycle as a push still accepts that push.
- Changing n_samples mid-run takes effect at the next compare. A value at or below the current count stops accepting at the next push attempt.

Optional Feature:
- Macro: DROP_COUNT_EN.
- Defined:
  - Adds port drop_count (out, 16): counts every cycle that would set overflow, saturating at 16'hFFFF.
  - Cleared by reset, by reset_op, and on the IDLE->RUN transition.
- Undefined: the port and counter are absent; only the sticky overflow exists.

Test Plan:
- n_samples=4, enable 0->1, 4 pushes of 64'h00000001_00000002 .. 64'h00000004_00000005, both readys=1 -> up_data 1,2,3,4 and down_data 2,3,4,5 one per cycle, starting the cycle after the first push; sample_count=4; finalizacion=1; in_ready=0 after the 4th push.
- Lane skew: up_ready=1, down_ready=0 for 3 cycles, then 1 -> up word taken once, up_valid low while down_valid stays high with stable data, pop only after the down handshake; sample_count increments once.
- Full: DEPTH=16, both readys=0, 20 consecutive in_valid in RUN -> in_ready falls after 16 pushes; overflow=1; drop_count=4 when DROP_COUNT_EN is defined.
- enable drop mid-run with 5 entries queued -> DRAIN, all 5 delivered, then DONE with finalizacion=1; enable stays 0 -> IDLE, finalizacion=0.
- reset_op pulse in RUN with 3 entries queued -> next cycle up_valid=0, down_valid=0, sample_count=0, state IDLE; async reset mid-DRAIN gives the same result immediately.
- n_samples=0, 300 pushes with readys=1 -> never leaves RUN, sample_count=300, finalizacion stays 0.
